// File: rtl/vedic_adder_sched.sv
// vedic_adder_sched: time-shares one external combinational N-bit adder
// between an 8x8 Vedic multiply channel (three adder passes) and a plain
// N-bit add channel (one pass). Round-robin arbitration in IDLE.
//
// Handshake rule used on every port pair: a transfer happens on the rising
// edge where valid and ready are both high; a producer holds valid and data
// stable until that edge, and ready never depends on valid.
module vedic_adder_sched #(
  parameter int N         = 12,
  parameter bit MUL_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mul_valid,
  output logic         mul_ready,
  input  logic [7:0]   mul_a,
  input  logic [7:0]   mul_b,
  input  logic         add_valid,
  output logic         add_ready,
  input  logic [N-1:0] add_x,
  input  logic [N-1:0] add_y,
  output logic         mul_out_valid,
  input  logic         mul_out_ready,
  output logic [15:0]  mul_product,
  output logic         add_out_valid,
  input  logic         add_out_ready,
  output logic [N-1:0] add_sum,
  output logic [N-1:0] adder_in1,
  output logic [N-1:0] adder_in2,
  input  logic [N-1:0] adder_answer,
  output logic [2:0]   dbg_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_M1     = 3'd1;
  localparam logic [2:0] S_M2     = 3'd2;
  localparam logic [2:0] S_M3     = 3'd3;
  localparam logic [2:0] S_A1     = 3'd4;
  localparam logic [2:0] S_WAIT_M = 3'd5;
  localparam logic [2:0] S_WAIT_A = 3'd6;

  // 2x2 Urdhva-Tiryagbhyam (vertical and crosswise) multiplier.
  function automatic logic [3:0] vedic2x2(input logic [1:0] a, input logic [1:0] b);
    logic       cross_c;
    logic [3:0] p;
    p[0]    = a[0] & b[0];
    p[1]    = (a[1] & b[0]) ^ (a[0] & b[1]);
    cross_c = (a[1] & b[0]) & (a[0] & b[1]);
    p[2]    = (a[1] & b[1]) ^ cross_c;
    p[3]    = (a[1] & b[1]) & cross_c;
    return p;
  endfunction

  // 4x4 Vedic multiplier assembled from four 2x2 blocks.
  function automatic logic [7:0] vedic4x4(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] q0, q1, q2, q3;
    q0 = vedic2x2(a[1:0], b[1:0]);
    q1 = vedic2x2(a[3:2], b[1:0]);
    q2 = vedic2x2(a[1:0], b[3:2]);
    q3 = vedic2x2(a[3:2], b[3:2]);
    return {4'h0, q0} + ({4'h0, q1} << 2) + ({4'h0, q2} << 2) + ({4'h0, q3} << 4);
  endfunction

  logic [2:0]   state_q, state_d;
  logic         ptr_q, ptr_d;          // 1: multiply channel holds priority
  logic [3:0]   al_q, al_d, ah_q, ah_d, bl_q, bl_d, bh_q, bh_d;
  logic [N-1:0] x_q, x_d, y_q, y_d;
  logic [11:0]  t_q, t_d;              // multiply accumulator, max 4064
  logic [15:0]  mul_product_q, mul_product_d;
  logic         mul_out_valid_q, mul_out_valid_d;
  logic [N-1:0] add_sum_q, add_sum_d;
  logic         add_out_valid_q, add_out_valid_d;

  logic [7:0]   pp0, pp1, pp2, pp3;
  logic         grant_mul, grant_add;

  assign pp0 = vedic4x4(al_q, bl_q);
  assign pp1 = vedic4x4(ah_q, bl_q);
  assign pp2 = vedic4x4(al_q, bh_q);
  assign pp3 = vedic4x4(ah_q, bh_q);

  // Ready only in IDLE; held low while reset is asserted so every output is 0.
  assign mul_ready = (state_q == S_IDLE) && !rst;
  assign add_ready = (state_q == S_IDLE) && !rst;

  // Round-robin: a lone request wins, a tie goes to the pointer's channel.
  assign grant_mul = mul_ready && mul_valid && (!add_valid || ptr_q);
  assign grant_add = add_ready && add_valid && (!mul_valid || !ptr_q);

  assign mul_product   = mul_product_q;
  assign mul_out_valid = mul_out_valid_q;
  assign add_sum       = add_sum_q;
  assign add_out_valid = add_out_valid_q;
  assign dbg_state     = state_q;

  // Shared adder operand mux; operands are zero-extended, idle/wait drive 0.
  always_comb begin
    adder_in1 = '0;
    adder_in2 = '0;
    case (state_q)
      S_M1: begin
        adder_in1[7:0] = pp1;
        adder_in2[7:0] = pp2;
      end
      S_M2: begin
        adder_in1[11:0] = t_q;
        adder_in2[3:0]  = pp0[7:4];
      end
      S_M3: begin
        adder_in1[11:0] = t_q;
        adder_in2[11:0] = {pp3, 4'h0};
      end
      S_A1: begin
        adder_in1 = x_q;
        adder_in2 = y_q;
      end
      default: ;
    endcase
  end

  // Next-state logic: arbitration, pass sequencing and result handshakes.
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    al_d            = al_q;
    ah_d            = ah_q;
    bl_d            = bl_q;
    bh_d            = bh_q;
    x_d             = x_q;
    y_d             = y_q;
    t_d             = t_q;
    mul_product_d   = mul_product_q;
    mul_out_valid_d = mul_out_valid_q;
    add_sum_d       = add_sum_q;
    add_out_valid_d = add_out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (grant_mul) begin
          al_d    = mul_a[3:0];
          ah_d    = mul_a[7:4];
          bl_d    = mul_b[3:0];
          bh_d    = mul_b[7:4];
          ptr_d   = 1'b0;
          state_d = S_M1;
        end else if (grant_add) begin
          x_d     = add_x;
          y_d     = add_y;
          ptr_d   = 1'b1;
          state_d = S_A1;
        end
      end
      S_M1: begin
        t_d     = adder_answer[11:0];
        state_d = S_M2;
      end
      S_M2: begin
        t_d     = adder_answer[11:0];
        state_d = S_M3;
      end
      S_M3: begin
        t_d             = adder_answer[11:0];
        mul_product_d   = {adder_answer[11:0], pp0[3:0]};
        mul_out_valid_d = 1'b1;
        state_d         = S_WAIT_M;
      end
      S_A1: begin
        add_sum_d       = adder_answer;
        add_out_valid_d = 1'b1;
        state_d         = S_WAIT_A;
      end
      S_WAIT_M: begin
        if (mul_out_ready) begin
          mul_out_valid_d = 1'b0;
          state_d         = S_IDLE;
        end
      end
      S_WAIT_A: begin
        if (add_out_ready) begin
          add_out_valid_d = 1'b0;
          state_d         = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      ptr_q           <= MUL_FIRST;
      al_q            <= '0;
      ah_q            <= '0;
      bl_q            <= '0;
      bh_q            <= '0;
      x_q             <= '0;
      y_q             <= '0;
      t_q             <= '0;
      mul_product_q   <= '0;
      mul_out_valid_q <= 1'b0;
      add_sum_q       <= '0;
      add_out_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      al_q            <= al_d;
      ah_q            <= ah_d;
      bl_q            <= bl_d;
      bh_q            <= bh_d;
      x_q             <= x_d;
      y_q             <= y_d;
      t_q             <= t_d;
      mul_product_q   <= mul_product_d;
      mul_out_valid_q <= mul_out_valid_d;
      add_sum_q       <= add_sum_d;
      add_out_valid_q <= add_out_valid_d;
    end
  end

endmodule

// File: tb/tb_vedic_adder_sched.sv
// Testbench for vedic_adder_sched: directed vector table, round-robin,
// backpressure and mid-operation reset sequences, plus a random sweep
// checked against plain-arithmetic expectations.
module tb_vedic_adder_sched;

  localparam int N = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mul_valid = 1'b0, mul_ready;
  logic [7:0]   mul_a = '0, mul_b = '0;
  logic         add_valid = 1'b0, add_ready;
  logic [N-1:0] add_x = '0, add_y = '0;
  logic         mul_out_valid, mul_out_ready = 1'b0;
  logic [15:0]  mul_product;
  logic         add_out_valid, add_out_ready = 1'b0;
  logic [N-1:0] add_sum;
  logic [N-1:0] adder_in1, adder_in2, adder_answer;
  logic [2:0]   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0]  mul_exp_q[$];
  logic [N-1:0] add_exp_q[$];
  logic [N-1:0] op1[3], op2[3];

  typedef struct {
    logic         is_mul;
    logic [7:0]   a, b;
    logic [N-1:0] x, y;
    logic [15:0]  exp_r;
  } vec_t;
  vec_t vecs[9];

  // Clock and external combinational adder
  always #5 clk = ~clk;
  assign adder_answer = adder_in1 + adder_in2;

  vedic_adder_sched #(.N(N), .MUL_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_a(mul_a), .mul_b(mul_b),
    .add_valid(add_valid), .add_ready(add_ready), .add_x(add_x), .add_y(add_y),
    .mul_out_valid(mul_out_valid), .mul_out_ready(mul_out_ready), .mul_product(mul_product),
    .add_out_valid(add_out_valid), .add_out_ready(add_out_ready), .add_sum(add_sum),
    .adder_in1(adder_in1), .adder_in2(adder_in2), .adder_answer(adder_answer),
    .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Multiply driver: handshake, latency check, scoreboard compare.
  task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input bit consume,
                         output logic [15:0] res);
    int cyc;
    int lat;
    logic [15:0] p;
    @(negedge clk);
    mul_a = a; mul_b = b; mul_valid = 1'b1;
    cyc = 0;
    while (!mul_ready && cyc < 50) begin @(negedge clk); cyc++; end
    check("mul_accept", mul_ready, 1);
    p = {8'h00, a};
    p = p * {8'h00, b};
    mul_exp_q.push_back(p);
    @(negedge clk);
    mul_valid = 1'b0;
    lat = 0;
    while (!mul_out_valid && lat < 20) begin
      if (lat < 3) begin op1[lat] = adder_in1; op2[lat] = adder_in2; end
      @(negedge clk);
      lat++;
    end
    check("mul_latency", lat, 3);
    res = mul_product;
    check("mul_product", mul_product, mul_exp_q.pop_front());
    if (consume) begin
      mul_out_ready = 1'b1;
      @(negedge clk);
      mul_out_ready = 1'b0;
      check("mul_valid_clear", mul_out_valid, 0);
    end
  endtask

  // Add driver: handshake, latency check, scoreboard compare.
  task automatic run_add(input logic [N-1:0] x, input logic [N-1:0] y, output logic [N-1:0] res);
    int cyc;
    int lat;
    logic [N:0] s;
    @(negedge clk);
    add_x = x; add_y = y; add_valid = 1'b1;
    cyc = 0;
    while (!add_ready && cyc < 50) begin @(negedge clk); cyc++; end
    check("add_accept", add_ready, 1);
    s = {1'b0, x} + {1'b0, y};
    add_exp_q.push_back(s[N-1:0]);
    @(negedge clk);
    add_valid = 1'b0;
    lat = 0;
    while (!add_out_valid && lat < 20) begin @(negedge clk); lat++; end
    check("add_latency", lat, 1);
    res = add_sum;
    check("add_sum", add_sum, add_exp_q.pop_front());
    add_out_ready = 1'b1;
    @(negedge clk);
    add_out_ready = 1'b0;
    check("add_valid_clear", add_out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0]  mres;
    logic [N-1:0] ares;
    int got, cyc, saw;

    vecs[0] = '{1'b1, 8'hFF, 8'hFF, 12'h000, 12'h000, 16'hFE01};
    vecs[1] = '{1'b1, 8'h0D, 8'h0B, 12'h000, 12'h000, 16'h008F};
    vecs[2] = '{1'b1, 8'h00, 8'hA7, 12'h000, 12'h000, 16'h0000};
    vecs[3] = '{1'b1, 8'h01, 8'hFF, 12'h000, 12'h000, 16'h00FF};
    vecs[4] = '{1'b1, 8'h80, 8'h80, 12'h000, 12'h000, 16'h4000};
    vecs[5] = '{1'b0, 8'h00, 8'h00, 12'hFFF, 12'h001, 16'h0000};
    vecs[6] = '{1'b0, 8'h00, 8'h00, 12'h123, 12'h456, 16'h0579};
    vecs[7] = '{1'b0, 8'h00, 8'h00, 12'hFFF, 12'hFFF, 16'h0FFE};
    vecs[8] = '{1'b0, 8'h00, 8'h00, 12'h800, 12'h7FF, 16'h0FFF};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mul_ready", mul_ready, 0);
    check("rst_add_ready", add_ready, 0);
    check("rst_mul_valid", mul_out_valid, 0);
    check("rst_add_valid", add_out_valid, 0);
    check("rst_product", mul_product, 0);
    check("rst_sum", add_sum, 0);
    check("rst_adder_in", {adder_in1, adder_in2}, 0);
    check("rst_state", dbg_state, 0);

    // Both requests on the first cycle after reset: expect mul, add, mul, add
    rst = 1'b0;
    mul_a = 8'h03; mul_b = 8'h05; mul_valid = 1'b1;
    add_x = 12'h00A; add_y = 12'h014; add_valid = 1'b1;
    #1;
    check("idle_ready", {mul_ready, add_ready}, 2'b11);
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      while (!mul_out_valid && !add_out_valid && cyc < 20) begin @(negedge clk); cyc++; end
      got = mul_out_valid ? 0 : (add_out_valid ? 1 : 2);
      check("rr_order", got, k % 2);
      check("rr_one_valid", {mul_out_valid, add_out_valid} == 2'b11, 0);
      if (got == 0) check("rr_product", mul_product, 16'd15);
      if (got == 1) check("rr_sum", add_sum, 12'd30);
      if (k == 3) begin mul_valid = 1'b0; add_valid = 1'b0; end
      if (got == 0) mul_out_ready = 1'b1;
      if (got == 1) add_out_ready = 1'b1;
      @(negedge clk);
      mul_out_ready = 1'b0;
      add_out_ready = 1'b0;
    end

    // 255*255 with the adder operand sequence
    run_mul(8'hFF, 8'hFF, 1'b1, mres);
    check("ops_m1", {op1[0], op2[0]}, {12'd225, 12'd225});
    check("ops_m2", {op1[1], op2[1]}, {12'd450, 12'd14});
    check("ops_m3", {op1[2], op2[2]}, {12'd464, 12'd3600});
    check("ff_product", mres, 16'hFE01);

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].is_mul) begin
        run_mul(vecs[i].a, vecs[i].b, 1'b1, mres);
        check("vec_mul", mres, vecs[i].exp_r);
      end else begin
        run_add(vecs[i].x, vecs[i].y, ares);
        check("vec_add", ares, vecs[i].exp_r[N-1:0]);
      end
    end

    // Random sweep: 1000 multiplies with interleaved adds
    for (int i = 0; i < 1000; i++) begin
      run_mul(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1, mres);
      if ($urandom_range(0, 3) == 0)
        run_add(N'($urandom), N'($urandom), ares);
    end

    // Backpressure on the product
    run_mul(8'h5A, 8'h3C, 1'b0, mres);
    mul_valid = 1'b1; add_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_product", mul_product, 16'h1518);
      check("bp_valid", mul_out_valid, 1);
      check("bp_ready", {mul_ready, add_ready}, 2'b00);
    end
    mul_valid = 1'b0; add_valid = 1'b0;
    mul_out_ready = 1'b1;
    @(negedge clk);
    mul_out_ready = 1'b0;
    check("bp_release_valid", mul_out_valid, 0);
    check("bp_release_idle", mul_ready, 1);
    check("bp_retained", mul_product, 16'h1518);

    // Reset during M2
    @(negedge clk);
    mul_a = 8'hFF; mul_b = 8'hFF; mul_valid = 1'b1;
    @(negedge clk);
    mul_valid = 1'b0;
    @(negedge clk);
    check("midop_in_m2", dbg_state, 3'd2);
    rst = 1'b1;
    #1;
    check("midop_product", mul_product, 0);
    check("midop_valids", {mul_out_valid, add_out_valid}, 0);
    check("midop_sum", add_sum, 0);
    check("midop_adder_in", {adder_in1, adder_in2}, 0);
    check("midop_ready", {mul_ready, add_ready}, 0);
    @(negedge clk);
    rst = 1'b0;
    saw = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mul_out_valid || add_out_valid) saw = 1;
    end
    check("midop_no_valid", saw, 0);
    run_mul(8'h02, 8'h03, 1'b1, mres);
    check("after_rst_product", mres, 16'h0006);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vedic_adder_sched.md
Name: vedic_adder_sched

Overview:
- Scheduler that time-shares one external combinational N-bit ripple adder between two requesters:
  - an 8x8 Vedic multiply channel, which needs three adder passes;
  - a plain N-bit add channel, which needs one pass.
- Forms the four 4x4 Vedic partial products internally and sequences their accumulation through the shared adder.
- Arbitrates round-robin between the two requesters and returns each result on its own valid/ready output.

Parameters:
- N, 12: shared adder width and add-channel operand width. Must be ≥12 because the multiply accumulation needs 12 bits.
- MUL_FIRST, 1: when 1, the multiply channel holds priority after reset; when 0, the add channel does.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mul_valid  in  1  multiply request valid.
- mul_ready  out  1  multiply request accepted when both valid and ready are high.
- mul_a  in  8  multiplicand.
- mul_b  in  8  multiplier.
- add_valid  in  1  add request valid.
- add_ready  out  1  add request accepted when both valid and ready are high.
- add_x  in  N  addend.
- add_y  in  N  addend.
- mul_out_valid  out  1  product valid.
- mul_out_ready  in  1  product consumed.
- mul_product  out  16  a*b.
- add_out_valid  out  1  sum valid.
- add_out_ready  in  1  sum consumed.
- add_sum  out  N  (x+y) mod 2^N.
- adder_in1  out  N  shared adder operand 1.
- adder_in2  out  N  shared adder operand 2.
- adder_answer  in  N  shared adder result, combinational from adder_in1/adder_in2.

Behaviour:
- Reset: all outputs are 0, state is IDLE, and the priority pointer is set to MUL_FIRST. Reset asserted mid-operation aborts the operation; partial results are discarded and never presented.
- States:
  - IDLE
  - M1, M2, M3
  - A1
  - WAIT_M, WAIT_A
- Request ready: mul_ready and add_ready are high only in IDLE. At most one request is accepted per edge.
- Arbitration in IDLE:
  - Only one valid: that channel is granted.
  - Both valid: the pointer's channel is granted, and the pointer then flips to the other channel.
  - A single-request grant also sets the pointer to the other channel.
- Multiply grant:
  - Latch al=a[3:0], ah=a[7:4], bl=b[3:0], bh=b[7:4], then go to M1.
  - Partial products: pp0=al*bl, pp1=ah*bl, pp2=al*bh, pp3=ah*bh (8 bits each).
  - Passes: the accumulator t is registered from adder_answer at each edge leaving M1, M2 and M3. Operands are zero-extended to N bits.
    - M1 drives pp1 and pp2.
    - M2 drives t and pp0[7:4].
    - M3 drives t and {pp3,4'h0}.
  - The maximum accumulated value is 4064, so no overflow occurs.
  - Leaving M3: mul_product <= {adder_answer[11:0], pp0[3:0]}, mul_out_valid <= 1, go to WAIT_M.
  - Latency: mul_out_valid rises 3 edges after the accept edge.
- Add grant:
  - Latch x and y, then go to A1.
  - A1 drives x and y. The next edge registers add_sum <= adder_answer and add_out_valid <= 1, then goes to WAIT_A.
  - Latency is 1 edge. Carry-out is dropped: the sum wraps modulo 2^N.
- WAIT_M / WAIT_A:
  - The result and its valid are held stable until the matching out_ready is high.
  - On that edge valid clears and the state returns to IDLE, so a new accept is possible on the next edge.
  - out_ready held low stalls indefinitely; no request is accepted meanwhile.
  - out_ready high before valid has no effect.
- adder_in1 and adder_in2 are 0 in IDLE, WAIT_M and WAIT_A.
- The product and sum registers retain their last value after their valid clears.

Test Plan:
- Multiply 255*255:
  - Reset, then mul_a=0xFF, mul_b=0xFF, mul_valid for 1 cycle.
  - Adder operands sequence (225,225), (450,14), (464,3600).
  - mul_product=0xFE01 with valid 3 edges after accept.
- Multiply 13*11:
  - mul_a=0x0D, mul_b=0x0B.
  - mul_product=0x008F.
  - Random sweep of 1000 pairs matches a*b.
- Add wrap:
  - add_x=0xFFF, add_y=0x001.
  - add_sum=0x000 and add_out_valid one edge after accept.
  - 0x123+0x456 gives 0x579.
- Simultaneous requests:
  - Both valid on the first cycle after reset with MUL_FIRST=1.
  - Multiply is served first; add is accepted only after the product is consumed. Then held requests alternate mul, add, mul.
- Backpressure:
  - Hold mul_out_ready=0 for 10 cycles.
  - mul_product and valid stay stable and mul_ready/add_ready stay 0. Releasing it returns to IDLE in one edge.
- Reset mid-op:
  - Assert rst during M2.
  - All outputs go to 0 immediately (asynchronously), with no valid afterwards.
  - A new 2*3 request then yields 0x0006.
